// File: rtl/tl_pkg.sv
// Transaction-layer shared types: completion/request commands for the TX
// framer, the 128-bit beat stream, TLP fmt/type codes and framer states.
package tl_pkg;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned HDR_W  = 96;
    localparam int unsigned CNT_W  = 11;

    // TLP fmt/type fields for 3DW headers
    localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
    localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
    localparam logic [4:0] TYPE_MEM       = 5'b00000;
    localparam logic [4:0] TYPE_CPL       = 5'b01010;

    // Completion command from the completion generator
    typedef struct packed {
        logic [15:0] requester_id;
        logic [7:0]  tag;
        logic [2:0]  status;
        logic [11:0] byte_count;
        logic [6:0]  lower_addr;
        logic        has_data;
        logic [31:0] data;
    } cpl_tx_t;

    // User-side memory request (payload arrives separately on wr_data)
    typedef struct packed {
        logic        is_write;
        logic [31:0] addr;
        logic [9:0]  length_dw;
        logic [7:0]  tag;
        logic [3:0]  first_be;
        logic [3:0]  last_be;
    } tx_req_t;

    // One 128-bit beat towards the DLL
    typedef struct packed {
        logic [127:0] data;
        logic         sop;
        logic         eop;
    } tl_stream_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_HDR,
        S_WR_HDR,
        S_WR_DATA,
        S_WR_FLUSH
    } tx_state_e;

    // A length field of zero encodes the maximum of 1024 DW
    function automatic logic [CNT_W-1:0] len_dw_full(input logic [9:0] len);
        return (len == 10'd0) ? 11'd1024 : {1'b0, len};
    endfunction

    // Keep DW positions below n, zero everything beyond the packet length
    function automatic logic [DATA_W-1:0] mask_dw(input logic [DATA_W-1:0] d,
                                                  input logic [CNT_W-1:0]  n);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            if (CNT_W'(k) < n) begin
                r[32*k +: 32] = d[32*k +: 32];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tl_tx_hdr_build.sv
// Combinational 3DW header packing for MRd/MWr requests and Cpl/CplD
// completions. DW3 of the result carries the completion payload for CplD
// and is zero otherwise; the framer overlays write payload for MWr.
module tl_tx_hdr_build
    import tl_pkg::*;
#(
    parameter logic [15:0] REQ_ID = 16'h0100
) (
    input  logic         is_cpl,
    input  cpl_tx_t      cpl,
    input  tx_req_t      req,
    output logic [127:0] hdr_beat
);

    // Address bits [1:0] are implied by the byte enables, not carried
    logic unused_addr_bits;
    assign unused_addr_bits = ^req.addr[1:0];

    // Pack header bytes little-endian by byte index; multi-byte fields big-endian
    always_comb begin
        hdr_beat = '0;
        if (is_cpl) begin
            hdr_beat[7:0]     = cpl.has_data ? {FMT_3DW_DATA, TYPE_CPL}
                                             : {FMT_3DW_NODATA, TYPE_CPL};
            hdr_beat[31:24]   = {7'd0, cpl.has_data};
            hdr_beat[39:32]   = REQ_ID[15:8];
            hdr_beat[47:40]   = REQ_ID[7:0];
            hdr_beat[55:53]   = cpl.status;
            hdr_beat[51:48]   = cpl.byte_count[11:8];
            hdr_beat[63:56]   = cpl.byte_count[7:0];
            hdr_beat[71:64]   = cpl.requester_id[15:8];
            hdr_beat[79:72]   = cpl.requester_id[7:0];
            hdr_beat[87:80]   = cpl.tag;
            hdr_beat[94:88]   = cpl.lower_addr;
            hdr_beat[127:96]  = cpl.has_data ? cpl.data : 32'd0;
        end else begin
            hdr_beat[7:0]     = req.is_write ? {FMT_3DW_DATA, TYPE_MEM}
                                             : {FMT_3DW_NODATA, TYPE_MEM};
            hdr_beat[17:16]   = req.length_dw[9:8];
            hdr_beat[31:24]   = req.length_dw[7:0];
            hdr_beat[39:32]   = REQ_ID[15:8];
            hdr_beat[47:40]   = REQ_ID[7:0];
            hdr_beat[55:48]   = req.tag;
            hdr_beat[59:56]   = req.first_be;
            hdr_beat[63:60]   = req.last_be;
            hdr_beat[71:64]   = req.addr[31:24];
            hdr_beat[79:72]   = req.addr[23:16];
            hdr_beat[87:80]   = req.addr[15:8];
            hdr_beat[95:88]   = {req.addr[7:2], 2'b00};
        end
    end

endmodule

// File: rtl/tl_tx_framer.sv
// Transaction-layer TX framer: arbitrates completions (strict priority) and
// user MRd/MWr requests at packet boundaries, prepends 3DW headers and
// shifts write payload by one DW so it follows the header seamlessly.
module tl_tx_framer
    import tl_pkg::*;
#(
    parameter logic [15:0] REQ_ID = 16'h0100
) (
    input  logic         clk,
    input  logic         rst_n,
    input  cpl_tx_t      cpl_req_i,
    input  logic         cpl_req_valid_i,
    output logic         cpl_req_ready_o,
    input  tx_req_t      req_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [127:0] wr_data_i,
    input  logic         wr_data_valid_i,
    output logic         wr_data_ready_o,
    output tl_stream_t   tl_tx_o,
    output logic         tl_tx_valid_o,
    input  logic         tl_tx_ready_i
);

    tx_state_e         state_reg;
    logic              run_reg;        // low during and one cycle after reset
    tx_req_t           req_reg;
    logic [95:0]       carry_reg;      // upper three DWs of the last popped input beat
    logic [CNT_W-1:0]  in_left_reg;    // input beats still to pop after the current one
    logic [CNT_W-1:0]  rem_reg;        // payload DWs not yet placed in an output beat
    tl_stream_t        out_reg;
    logic              valid_reg;

    logic              slot_free;
    logic              hdr_is_cpl;
    logic [127:0]      hdr_beat;
    logic [CNT_W-1:0]  req_len_full;
    logic [CNT_W-1:0]  req_in_beats;
    logic              wr_pop;

    // Output register may be reloaded when empty or being drained this cycle
    assign slot_free = !valid_reg || tl_tx_ready_i;

    // In idle the header path serves completions; otherwise the latched request
    assign hdr_is_cpl = (state_reg == S_IDLE);

    tl_tx_hdr_build #(
        .REQ_ID (REQ_ID)
    ) u_hdr_build (
        .is_cpl   (hdr_is_cpl),
        .cpl      (cpl_req_i),
        .req      (req_reg),
        .hdr_beat (hdr_beat)
    );

    // Payload bookkeeping derived from the request being accepted
    assign req_len_full = len_dw_full(req_i.length_dw);
    assign req_in_beats = (req_len_full + 11'd3) >> 2;

    // Handshakes: readiness only ever implies that the output slot can take a beat
    assign cpl_req_ready_o = run_reg && (state_reg == S_IDLE) && slot_free;
    assign req_ready_o     = cpl_req_ready_o && !cpl_req_valid_i;
    assign wr_data_ready_o = run_reg && slot_free &&
                             ((state_reg == S_WR_HDR) ||
                              ((state_reg == S_WR_DATA) && (in_left_reg != '0)));
    assign wr_pop          = wr_data_ready_o && wr_data_valid_i;

    assign tl_tx_o       = out_reg;
    assign tl_tx_valid_o = valid_reg;

    // Framer FSM with carry register, counters and the registered output beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            run_reg     <= 1'b0;
            req_reg     <= '0;
            carry_reg   <= '0;
            in_left_reg <= '0;
            rem_reg     <= '0;
            out_reg     <= '0;
            valid_reg   <= 1'b0;
        end else begin
            run_reg <= 1'b1;
            // A drained beat leaves the slot empty unless a new one is loaded below
            if (slot_free) begin
                valid_reg <= 1'b0;
            end

            case (state_reg)
                S_IDLE: begin
                    if (run_reg && slot_free) begin
                        if (cpl_req_valid_i) begin
                            out_reg.data <= hdr_beat;
                            out_reg.sop  <= 1'b1;
                            out_reg.eop  <= 1'b1;
                            valid_reg    <= 1'b1;
                        end else if (req_valid_i) begin
                            req_reg     <= req_i;
                            rem_reg     <= req_len_full - 11'd1;
                            in_left_reg <= req_in_beats - 11'd1;
                            state_reg   <= req_i.is_write ? S_WR_HDR : S_RD_HDR;
                        end
                    end
                end

                S_RD_HDR: begin
                    if (slot_free) begin
                        out_reg.data <= hdr_beat;
                        out_reg.sop  <= 1'b1;
                        out_reg.eop  <= 1'b1;
                        valid_reg    <= 1'b1;
                        state_reg    <= S_IDLE;
                    end
                end

                S_WR_HDR: begin
                    if (wr_pop) begin
                        out_reg.data <= {wr_data_i[31:0], hdr_beat[95:0]};
                        out_reg.sop  <= 1'b1;
                        out_reg.eop  <= (rem_reg == '0);
                        valid_reg    <= 1'b1;
                        carry_reg    <= wr_data_i[127:32];
                        if (rem_reg == '0) begin
                            state_reg <= S_IDLE;
                        end else if (in_left_reg == '0) begin
                            state_reg <= S_WR_FLUSH;
                        end else begin
                            state_reg <= S_WR_DATA;
                        end
                    end
                end

                S_WR_DATA: begin
                    if (wr_pop) begin
                        out_reg.data <= mask_dw({wr_data_i[31:0], carry_reg}, rem_reg);
                        out_reg.sop  <= 1'b0;
                        out_reg.eop  <= (rem_reg <= 11'd4);
                        valid_reg    <= 1'b1;
                        carry_reg    <= wr_data_i[127:32];
                        in_left_reg  <= in_left_reg - 11'd1;
                        rem_reg      <= (rem_reg > 11'd4) ? (rem_reg - 11'd4) : '0;
                        // A length of 4k+1 ends exactly on the last input beat
                        if (rem_reg <= 11'd4) begin
                            state_reg <= S_IDLE;
                        end else if (in_left_reg == 11'd1) begin
                            state_reg <= S_WR_FLUSH;
                        end
                    end
                end

                S_WR_FLUSH: begin
                    if (slot_free) begin
                        out_reg.data <= mask_dw({32'd0, carry_reg}, rem_reg);
                        out_reg.sop  <= 1'b0;
                        out_reg.eop  <= 1'b1;
                        valid_reg    <= 1'b1;
                        rem_reg      <= '0;
                        state_reg    <= S_IDLE;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tl_tx_framer.sv
// Directed bench for tl_tx_framer: completions, MRd, MWr alignment and flush,
// backpressure, arbitration, maximum length and reset mid-packet.
module tb_tl_tx_framer;
    import tl_pkg::*;

    logic         clk;
    logic         rst_n;
    cpl_tx_t      cpl_req_i;
    logic         cpl_req_valid_i;
    logic         cpl_req_ready_o;
    tx_req_t      req_i;
    logic         req_valid_i;
    logic         req_ready_o;
    logic [127:0] wr_data_i;
    logic         wr_data_valid_i;
    logic         wr_data_ready_o;
    tl_stream_t   tl_tx_o;
    logic         tl_tx_valid_o;
    logic         tl_tx_ready_i;

    tl_tx_framer #(
        .REQ_ID (16'h0100)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cpl_req_i       (cpl_req_i),
        .cpl_req_valid_i (cpl_req_valid_i),
        .cpl_req_ready_o (cpl_req_ready_o),
        .req_i           (req_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .wr_data_i       (wr_data_i),
        .wr_data_valid_i (wr_data_valid_i),
        .wr_data_ready_o (wr_data_ready_o),
        .tl_tx_o         (tl_tx_o),
        .tl_tx_valid_o   (tl_tx_valid_o),
        .tl_tx_ready_i   (tl_tx_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           pop_cnt  = 0;
    int           cpl_acc_cyc = -1;
    int           req_acc_cyc = -1;
    logic [127:0] wq[$];
    tl_stream_t   obs_q[$];
    int           obs_cyc[$];

    task automatic check(input string tag, input logic [129:0] obs, input logic [129:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [129:0] bt(input logic [127:0] d, input logic s, input logic e);
        return {d, s, e};
    endfunction

    function automatic logic [127:0] pk(input logic [31:0] base);
        return {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    function automatic logic [31:0] dwv(input int j, input int k);
        return {8'hC4, 8'h00, 8'(j), 8'(k)};
    endfunction

    // One clock: drive write data from the queue, sample handshakes at the
    // falling edge, then return one time unit after the rising edge.
    task automatic cycle();
        logic cpl_taken;
        logic req_taken;
        cpl_taken = 1'b0;
        req_taken = 1'b0;
        wr_data_valid_i = (wq.size() != 0);
        wr_data_i       = (wq.size() != 0) ? wq[0] : '0;
        @(negedge clk);
        if (cpl_req_valid_i && cpl_req_ready_o) begin
            cpl_acc_cyc = cyc;
            cpl_taken   = 1'b1;
        end
        if (req_valid_i && req_ready_o) begin
            req_acc_cyc = cyc;
            req_taken   = 1'b1;
        end
        if (wr_data_valid_i && wr_data_ready_o) begin
            void'(wq.pop_front());
            pop_cnt++;
        end
        if (tl_tx_valid_o && tl_tx_ready_i) begin
            obs_q.push_back(tl_tx_o);
            obs_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (cpl_taken) cpl_req_valid_i = 1'b0;
        if (req_taken) req_valid_i = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int n, input int limit);
        for (int k = 0; k < limit && obs_q.size() < n; k++) cycle();
        check(tag, 130'(obs_q.size()), 130'(n));
    endtask

    task automatic set_req(input logic w, input logic [31:0] a, input logic [9:0] l,
                           input logic [7:0] t, input logic [3:0] fbe, input logic [3:0] lbe);
        req_i.is_write  = w;
        req_i.addr      = a;
        req_i.length_dw = l;
        req_i.tag       = t;
        req_i.first_be  = fbe;
        req_i.last_be   = lbe;
        req_valid_i     = 1'b1;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        tl_stream_t snap;

        rst_n           = 1'b0;
        cpl_req_i       = '0;
        cpl_req_valid_i = 1'b0;
        req_i           = '0;
        req_valid_i     = 1'b0;
        wr_data_i       = '0;
        wr_data_valid_i = 1'b0;
        tl_tx_ready_i   = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 130'(tl_tx_valid_o), 130'(0));
        check("rst_data", tl_tx_o, '0);
        check("rst_cpl_rdy", 130'(cpl_req_ready_o), 130'(0));
        check("rst_req_rdy", 130'(req_ready_o), 130'(0));
        check("rst_wr_rdy", 130'(wr_data_ready_o), 130'(0));
        rst_n = 1'b1;
        repeat (2) cycle();

        // CplD single beat, latency 1
        cpl_req_i.requester_id = 16'h0200;
        cpl_req_i.tag          = 8'h2A;
        cpl_req_i.status       = 3'd0;
        cpl_req_i.byte_count   = 12'd4;
        cpl_req_i.lower_addr   = 7'h10;
        cpl_req_i.has_data     = 1'b1;
        cpl_req_i.data         = 32'hDEADBEEF;
        cpl_req_valid_i        = 1'b1;
        wait_beats("cpld_count", 1, 20);
        check("cpld_beat", obs_q[0], bt(128'hDEADBEEF_102A0002_04000001_0100004A, 1'b1, 1'b1));
        check("cpld_latency", 130'(obs_cyc[0] - cpl_acc_cyc), 130'(1));
        repeat (2) cycle();
        clear_obs();

        // MRd single beat, latency 2
        set_req(1'b0, 32'h0000_1004, 10'd4, 8'h05, 4'hF, 4'hF);
        wait_beats("mrd_count", 1, 20);
        check("mrd_beat", obs_q[0], bt(128'h00000000_04100000_FF050001_04000000, 1'b1, 1'b1));
        check("mrd_latency", 130'(obs_cyc[0] - req_acc_cyc), 130'(2));
        repeat (2) cycle();
        clear_obs();

        // MWr L=5: two beats, last input beat closes the packet
        p0 = pop_cnt;
        wq.push_back(pk(32'hA000_0000));
        wq.push_back(pk(32'hB000_0000));
        set_req(1'b1, 32'h2000_0008, 10'd5, 8'h01, 4'hF, 4'hF);
        wait_beats("mwr5_count", 2, 40);
        repeat (3) cycle();
        check("mwr5_no_flush", 130'(obs_q.size()), 130'(2));
        check("mwr5_b0", obs_q[0], bt(128'hA0000000_08000020_FF010001_05000040, 1'b1, 1'b0));
        check("mwr5_b1", obs_q[1], bt(128'hB0000000_A0000003_A0000002_A0000001, 1'b0, 1'b1));
        check("mwr5_pops", 130'(pop_cnt - p0), 130'(2));
        clear_obs();

        // MWr L=6: flush beat carries in1[63:32]
        p0 = pop_cnt;
        wq.push_back(pk(32'hC000_0000));
        wq.push_back(pk(32'hD000_0000));
        set_req(1'b1, 32'h0000_0100, 10'd6, 8'h02, 4'hF, 4'hF);
        wait_beats("mwr6_count", 3, 40);
        check("mwr6_b0", obs_q[0], bt(128'hC0000000_00010000_FF020001_06000040, 1'b1, 1'b0));
        check("mwr6_b1", obs_q[1], bt(128'hD0000000_C0000003_C0000002_C0000001, 1'b0, 1'b0));
        check("mwr6_b2", obs_q[2], bt(128'h00000000_00000000_00000000_D0000001, 1'b0, 1'b1));
        check("mwr6_pops", 130'(pop_cnt - p0), 130'(2));
        repeat (2) cycle();
        clear_obs();

        // MWr L=9 with three cycles of backpressure after the header beat
        p0 = pop_cnt;
        wq.push_back(pk(32'hE000_0000));
        wq.push_back(pk(32'hF000_0000));
        wq.push_back(pk(32'h6000_0000));
        set_req(1'b1, 32'h0000_3000, 10'd9, 8'h04, 4'hF, 4'hF);
        wait_beats("bp_first", 1, 40);
        tl_tx_ready_i = 1'b0;
        snap = tl_tx_o;
        p0   = pop_cnt;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("bp_stable", tl_tx_o, snap);
            check("bp_valid", 130'(tl_tx_valid_o), 130'(1));
            check("bp_wr_rdy", 130'(wr_data_ready_o), 130'(0));
        end
        check("bp_no_pops", 130'(pop_cnt), 130'(p0));
        tl_tx_ready_i = 1'b1;
        wait_beats("bp_count", 3, 40);
        check("bp_b0", obs_q[0], bt(128'hE0000000_00300000_FF040001_09000040, 1'b1, 1'b0));
        check("bp_b1", obs_q[1], bt(128'hF0000000_E0000003_E0000002_E0000001, 1'b0, 1'b0));
        check("bp_b2", obs_q[2], bt(128'h60000000_F0000003_F0000002_F0000001, 1'b0, 1'b1));
        repeat (2) cycle();
        clear_obs();

        // Completion and request together: completion wins, request next
        cpl_req_i.requester_id = 16'h0300;
        cpl_req_i.tag          = 8'h07;
        cpl_req_i.status       = 3'd0;
        cpl_req_i.byte_count   = 12'd8;
        cpl_req_i.lower_addr   = 7'h04;
        cpl_req_i.has_data     = 1'b0;
        cpl_req_i.data         = 32'h1234_5678;
        cpl_req_valid_i        = 1'b1;
        set_req(1'b0, 32'hFFFF_FFFC, 10'd1, 8'h09, 4'hF, 4'h0);
        #1;
        check("arb_req_rdy", 130'(req_ready_o), 130'(0));
        wait_beats("arb_count", 2, 40);
        check("arb_b0_cpl", obs_q[0], bt(128'h00000000_04070003_08000001_0000000A, 1'b1, 1'b1));
        check("arb_b1_mrd", obs_q[1], bt(128'h00000000_FCFFFFFF_0F090001_01000000, 1'b1, 1'b1));
        check("arb_order", 130'(req_acc_cyc - cpl_acc_cyc), 130'(1));
        repeat (2) cycle();
        clear_obs();

        // Maximum length: length_dw 0 means 1024 DW, 257 output beats
        p0 = pop_cnt;
        for (int j = 0; j < 256; j++) wq.push_back({dwv(j, 3), dwv(j, 2), dwv(j, 1), dwv(j, 0)});
        set_req(1'b1, 32'h1000_0000, 10'd0, 8'h06, 4'hF, 4'hF);
        wait_beats("max_count", 257, 700);
        repeat (3) cycle();
        check("max_no_extra", 130'(obs_q.size()), 130'(257));
        check("max_hdr_dw0", 130'(obs_q[0].data[31:0]), 130'(32'h0000_0040));
        check("max_hdr_dw3", 130'(obs_q[0].data[127:96]), 130'(dwv(0, 0)));
        check("max_b1", obs_q[1], bt({dwv(1, 0), dwv(0, 3), dwv(0, 2), dwv(0, 1)}, 1'b0, 1'b0));
        check("max_last", obs_q[256], bt({32'd0, dwv(255, 3), dwv(255, 2), dwv(255, 1)}, 1'b0, 1'b1));
        check("max_pops", 130'(pop_cnt - p0), 130'(256));
        clear_obs();

        // Reset in the middle of an MWr, then a clean L=2 packet
        wq.push_back(pk(32'h7000_0000));
        wq.push_back(pk(32'h8000_0000));
        set_req(1'b1, 32'h0000_0000, 10'd8, 8'h07, 4'hF, 4'hF);
        wait_beats("rstmid_first", 1, 40);
        rst_n = 1'b0;
        #1;
        check("rstmid_valid", 130'(tl_tx_valid_o), 130'(0));
        check("rstmid_wr_rdy", 130'(wr_data_ready_o), 130'(0));
        wq.delete();
        req_valid_i     = 1'b0;
        wr_data_valid_i = 1'b0;
        cycle();
        rst_n = 1'b1;
        repeat (2) cycle();
        clear_obs();
        p0 = pop_cnt;
        wq.push_back(pk(32'h5000_0000));
        set_req(1'b1, 32'h0000_0040, 10'd2, 8'h03, 4'hF, 4'hF);
        wait_beats("post_rst_count", 2, 40);
        check("post_rst_b0", obs_q[0], bt(128'h50000000_40000000_FF030001_02000040, 1'b1, 1'b0));
        check("post_rst_b1", obs_q[1], bt(128'h00000000_00000000_00000000_50000001, 1'b0, 1'b1));
        check("post_rst_pops", 130'(pop_cnt - p0), 130'(1));
        repeat (2) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
